// File: rtl/seq_pkg.sv
// Shared encodings for the serial pattern transmitter and its matching detector.
package seq_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_SEND = 2'd1;
  localparam logic [STATE_W-1:0] ST_GAP  = 2'd2;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd3;

  function automatic logic is_busy(input logic [STATE_W-1:0] st);
    return st != ST_IDLE;
  endfunction

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down counter with a registered zero flag; load wins over decrement.
module seq_down_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_nxt;

  always_comb begin
    count_nxt = count_q;
    if (load) begin
      count_nxt = load_val;
    end else if (dec) begin
      count_nxt = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      zero    <= 1'b1;
    end else begin
      count_q <= count_nxt;
      zero    <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern burst transmitter: sends a latched frame MSB-first a number of
// times, with optional idle gaps between frames, then pulses done.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int unsigned PAT_W = 3,
  parameter int unsigned RPT_W = 4,
  parameter int unsigned GAP_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [RPT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  output logic             seq_out,
  output logic             seq_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_out
);

  localparam int unsigned BIT_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;

  logic [STATE_W-1:0] state_q, state_nxt;
  logic [PAT_W-1:0]   pat_q, pat_nxt;
  logic [PAT_W-1:0]   sh_q, sh_nxt;
  logic [GAP_W-1:0]   gap_q, gap_nxt;

  logic             bit_load, bit_dec, bit_zero;
  logic             frm_load, frm_dec, frm_zero;
  logic [RPT_W-1:0] frm_load_val;
  logic             gap_load, gap_dec, gap_zero;
  logic [GAP_W-1:0] gap_load_val;

  // Counters hold "remaining after this one", so zero marks the final bit/frame/gap cycle.
  seq_down_counter #(.W(BIT_W)) u_bit_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (bit_load),
    .load_val (BIT_W'(PAT_W - 1)),
    .dec      (bit_dec),
    .zero     (bit_zero)
  );

  seq_down_counter #(.W(RPT_W)) u_frm_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (frm_load),
    .load_val (frm_load_val),
    .dec      (frm_dec),
    .zero     (frm_zero)
  );

  seq_down_counter #(.W(GAP_W)) u_gap_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load),
    .load_val (gap_load_val),
    .dec      (gap_dec),
    .zero     (gap_zero)
  );

  assign gap_load_val = gap_q - GAP_W'(1);
  assign state_out    = state_q;

  // Next-state, latch and counter control.
  always_comb begin
    state_nxt    = state_q;
    pat_nxt      = pat_q;
    gap_nxt      = gap_q;
    sh_nxt       = sh_q;
    bit_load     = 1'b0;
    bit_dec      = 1'b0;
    frm_load     = 1'b0;
    frm_dec      = 1'b0;
    frm_load_val = '0;
    gap_load     = 1'b0;
    gap_dec      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_nxt    = ST_SEND;
          pat_nxt      = pattern;
          gap_nxt      = gap;
          sh_nxt       = pattern;
          bit_load     = 1'b1;
          frm_load     = 1'b1;
          frm_load_val = (repeat_cnt == '0) ? '0 : repeat_cnt - RPT_W'(1);
        end
      end
      ST_SEND: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (!bit_zero) begin
          bit_dec = 1'b1;
          sh_nxt  = {sh_q[PAT_W-2:0], 1'b0};
        end else if (frm_zero) begin
          state_nxt = ST_DONE;
        end else begin
          frm_dec = 1'b1;
          if (gap_q == '0) begin
            bit_load = 1'b1;
            sh_nxt   = pat_q;
          end else begin
            state_nxt = ST_GAP;
            gap_load  = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (gap_zero) begin
          state_nxt = ST_SEND;
          bit_load  = 1'b1;
          sh_nxt    = pat_q;
        end else begin
          gap_dec = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, latched burst parameters and registered Moore outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pat_q     <= '0;
      sh_q      <= '0;
      gap_q     <= '0;
      seq_out   <= 1'b0;
      seq_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      pat_q     <= pat_nxt;
      sh_q      <= sh_nxt;
      gap_q     <= gap_nxt;
      seq_out   <= (state_nxt == ST_SEND) && sh_nxt[PAT_W-1];
      seq_valid <= (state_nxt == ST_SEND);
      busy      <= is_busy(state_nxt);
      done      <= (state_nxt == ST_DONE);
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: per-cycle expected outputs are queued when
// a burst is launched and compared against the DUT each cycle.
module tb_seq_pattern_tx;
  import seq_pkg::*;

  localparam int unsigned PAT_W = 3;
  localparam int unsigned RPT_W = 4;
  localparam int unsigned GAP_W = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic [RPT_W-1:0] repeat_cnt = '0;
  logic [GAP_W-1:0] gap = '0;
  logic             abort = 1'b0;
  logic             seq_out, seq_valid, busy, done;
  logic [1:0]       state_out;

  int checks = 0;
  int errors = 0;
  int det_cnt, busy_cycles;

  logic [5:0] exp_q[$];
  logic [2:0] hist;
  int         nbits;

  seq_pattern_tx #(.PAT_W(PAT_W), .RPT_W(RPT_W), .GAP_W(GAP_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pattern    (pattern),
    .repeat_cnt (repeat_cnt),
    .gap        (gap),
    .abort      (abort),
    .seq_out    (seq_out),
    .seq_valid  (seq_valid),
    .busy       (busy),
    .done       (done),
    .state_out  (state_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] obs();
    return {state_out, busy, done, seq_valid, seq_out};
  endfunction

  function automatic logic [5:0] mk(input logic [1:0] st, input logic b, input logic d,
                                    input logic v, input logic o);
    return {st, b, d, v, o};
  endfunction

  // Non-overlapping 101 detector fed by the valid serial stream.
  task automatic detect_feed(input logic b);
    hist = {hist[1:0], b};
    nbits++;
    if (nbits >= 3 && hist == 3'b101) begin
      det_cnt++;
      nbits = 0;
    end
  endtask

  task automatic run_burst(input string tag, input logic [PAT_W-1:0] pat,
                           input logic [RPT_W-1:0] rpt, input logic [GAP_W-1:0] gp,
                           input int abort_at, input int reset_at,
                           input bit hold_start, input bit start_done);
    int frames, n;
    logic [5:0] e;
    exp_q.delete();
    frames = (rpt == 0) ? 1 : int'(rpt);
    for (int f = 0; f < frames; f++) begin
      for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back(mk(ST_SEND, 1, 0, 1, pat[b]));
      if (f < frames - 1)
        for (int g = 0; g < int'(gp); g++) exp_q.push_back(mk(ST_GAP, 1, 0, 0, 0));
    end
    exp_q.push_back(mk(ST_DONE, 1, 1, 0, 0));
    exp_q.push_back(mk(ST_IDLE, 0, 0, 0, 0));
    if (abort_at > 0) begin
      while (exp_q.size() > abort_at) void'(exp_q.pop_back());
      exp_q.push_back(mk(ST_IDLE, 0, 0, 0, 0));
    end
    det_cnt = 0; nbits = 0; hist = '0; busy_cycles = 0;

    @(negedge clk);
    start = 1'b1; pattern = pat; repeat_cnt = rpt; gap = gp;
    n = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      n++;
      e = exp_q.pop_front();
      check($sformatf("%s cyc%0d", tag, n), 32'(obs()), 32'(e));
      if (seq_valid) detect_feed(seq_out);
      if (busy) busy_cycles++;
      pattern    = ~pat;
      repeat_cnt = RPT_W'($urandom);
      gap        = GAP_W'($urandom);
      start      = hold_start && (n < int'(PAT_W));
      if (start_done && exp_q.size() == 1) start = 1'b1;
      abort      = (n == abort_at);
      if (n == reset_at) begin
        #2 reset = 1'b0;
        #1 check($sformatf("%s async_reset", tag), 32'(obs()), 32'(0));
        exp_q.delete();
        exp_q.push_back(mk(ST_IDLE, 0, 0, 0, 0));
        @(negedge clk);
        reset = 1'b1;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check($sformatf("%s stay_idle", tag), 32'(obs()), 32'(0));
  endtask

  initial begin
    #1 check("reset_outputs", 32'(obs()), 32'(0));
    repeat (2) @(negedge clk);
    check("reset_held", 32'(obs()), 32'(0));
    reset = 1'b1;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_in_idle", 32'(obs()), 32'(0));

    run_burst("single", 3'b101, 4'd1, 2'd0, 0, 0, 0, 0);
    run_burst("b2b",    3'b101, 4'd3, 2'd0, 0, 0, 0, 1);
    check("b2b_busy_cycles", 32'(busy_cycles), 32'd10);
    check("b2b_detections",  32'(det_cnt),     32'd3);
    run_burst("gapped", 3'b110, 4'd2, 2'd2, 0, 0, 1, 0);
    run_burst("abort",  3'b101, 4'd4, 2'd1, 6, 0, 0, 0);
    run_burst("rst",    3'b110, 4'd2, 2'd2, 0, 4, 0, 0);
    run_burst("rpt0",   3'b011, 4'd0, 2'd3, 0, 0, 0, 0);
    run_burst("loop",   3'b101, 4'd5, 2'd1, 0, 0, 0, 0);
    check("loop_detections", 32'(det_cnt), 32'd5);
    run_burst("maxrpt", 3'b100, 4'd15, 2'd3, 0, 0, 0, 1);

    for (int i = 0; i < 6; i++) begin
      run_burst($sformatf("rand%0d", i), PAT_W'($urandom_range(0, 7)),
                RPT_W'($urandom_range(0, 4)), GAP_W'($urandom_range(0, 3)),
                0, 0, bit'($urandom_range(0, 1)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
